// File: rtl/hash_q_bank.sv
// rtl/hash_q_bank.sv - double-buffered, LFSR-seedable Q-matrix store for the H3 hash datapath
module hash_q_bank #(
    parameter int          KEY_WIDTH   = 32,
    parameter int          INDEX_WIDTH = 12,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
    parameter int          ROW_AW      = $clog2(KEY_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ROW_AW-1:0]                wr_row,
    input  logic [INDEX_WIDTH-1:0]           wr_data,
    input  logic                             regen_start,
    input  logic [31:0]                      regen_seed,
    input  logic                             commit,
    output logic                             busy,
    output logic                             ready,
    output logic                             regen_done,
    output logic                             wr_err,
    output logic [7:0]                       version,
    output logic [KEY_WIDTH*INDEX_WIDTH-1:0] hash_q_out
);
    localparam logic [31:0]       TAPS      = 32'h8020_0003;
    localparam logic [ROW_AW:0]   ROW_LIMIT = (ROW_AW+1)'(KEY_WIDTH);
    localparam logic [ROW_AW-1:0] LAST_ROW  = ROW_AW'(KEY_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_COMMIT} state_t;

    state_t                          state;
    state_t                          state_next;
    logic                            init_pending;
    logic [31:0]                     lfsr;
    logic [31:0]                     lfsr_step;
    logic [ROW_AW-1:0]               row_ptr;
    logic [INDEX_WIDTH-1:0]          shadow [KEY_WIDTH];
    logic [INDEX_WIDTH-1:0]          candidate;
    logic                            cand_ok;
    logic                            gen_last;
    logic                            row_in_range;
    logic                            host_wr;
    logic                            idle_regen;
    logic                            idle_commit;
    logic [KEY_WIDTH*INDEX_WIDTH-1:0] bank_next;

    always_comb begin
        lfsr_step    = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
        candidate    = lfsr_step[INDEX_WIDTH-1:0];
        cand_ok      = (candidate != '0);
        gen_last     = cand_ok && (row_ptr == LAST_ROW);
        row_in_range = ({1'b0, wr_row} < ROW_LIMIT);
        idle_regen   = (state == S_IDLE) && regen_start;
        idle_commit  = (state == S_IDLE) && commit && !regen_start;
        host_wr      = (state == S_IDLE) && wr_en && row_in_range;

        state_next = state;
        case (state)
            S_IDLE:   if (regen_start) state_next = S_GEN;
            S_GEN:    if (gen_last) state_next = init_pending ? S_COMMIT : S_IDLE;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Shadow contents as they will be after this cycle's host write, so an
    // IDLE commit captures a same-cycle write.
    always_comb begin
        bank_next = '0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            bank_next[i*INDEX_WIDTH +: INDEX_WIDTH] =
                (host_wr && (wr_row == ROW_AW'(i))) ? wr_data : shadow[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_GEN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_WIDTH; i++) shadow[i] <= '0;
            hash_q_out   <= '0;
            busy         <= 1'b1;
            ready        <= 1'b0;
            regen_done   <= 1'b0;
            wr_err       <= 1'b0;
            version      <= 8'd0;
            lfsr         <= LFSR_SEED;
            row_ptr      <= '0;
            init_pending <= 1'b1;
        end else begin
            busy       <= (state_next != S_IDLE);
            regen_done <= (state == S_GEN) && gen_last;
            wr_err     <= wr_en && ((state != S_IDLE) || !row_in_range);

            if (host_wr) shadow[wr_row] <= wr_data;

            // Zero candidates are skipped so no generated row is ever all-zero.
            if (state == S_GEN) begin
                lfsr <= lfsr_step;
                if (cand_ok) begin
                    shadow[row_ptr] <= candidate;
                    if (!gen_last) row_ptr <= row_ptr + 1'b1;
                end
            end

            if (idle_regen) begin
                lfsr    <= (regen_seed == 32'd0) ? LFSR_SEED : regen_seed;
                row_ptr <= '0;
            end

            if ((state == S_COMMIT) || idle_commit) begin
                hash_q_out <= bank_next;
                version    <= version + 8'd1;
                ready      <= 1'b1;
            end

            if (state == S_COMMIT) init_pending <= 1'b0;
        end
    end
endmodule
